// File: rtl/gate_sequencer.sv
// Frequency-counter gate sequencer: clears the counter, opens a decade-scaled gate, settles, then hands off to the display.
// Define GATE_SEQUENCER_AUTORANGE_EN to let overflow / leading-zero feedback pick the range instead of range_in.
module gate_sequencer #(
    parameter int GATE_BASE     = 1000,
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       start_in,
    input  logic [1:0] range_in,
    input  logic       cnt_overflow_in,
    input  logic       cnt_msd_zero_in,
    input  logic       streamer_ready_in,
    output logic       cnt_enable_out,
    output logic       cnt_reset_out,
    output logic       refresh_stb_out,
    output logic [1:0] range_out,
    output logic [2:0] dec_point_out,
    output logic       overflow_out,
    output logic       busy_out
);
    typedef enum logic [2:0] {
        IDLE, CLEAR, GATE, SETTLE, REFRESH, WAIT_ACK, WAIT_DONE
    } state_t;

    localparam logic [31:0] CLEAR_LOAD  = 32'(CLEAR_CYCLES - 1);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GATE_LOAD_0 = 32'(GATE_BASE - 1);
    localparam logic [31:0] GATE_LOAD_1 = 32'(GATE_BASE * 10 - 1);
    localparam logic [31:0] GATE_LOAD_2 = 32'(GATE_BASE * 100 - 1);
    localparam logic [31:0] GATE_LOAD_3 = 32'(GATE_BASE * 1000 - 1);

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] gate_load;
    logic        ovf_acc_reg, ovf_acc_next;
    logic        overflow_reg, overflow_next;
    logic [1:0]  meas_range_reg, meas_range_next;
    logic [1:0]  range_src;
    logic        load_range;
    logic        refresh_stb_next;
    logic        cnt_enable_reg, cnt_reset_reg, refresh_stb_reg, busy_reg;
    logic        ovf_final;
    logic        settle_done;

    assign ovf_final   = ovf_acc_reg | cnt_overflow_in;
    assign settle_done = (state_reg == SETTLE) && (cnt_reg == 32'd0);

`ifdef GATE_SEQUENCER_AUTORANGE_EN
    // Range chosen for the next measurement; range_out keeps the completed one until CLEAR.
    logic [1:0] auto_range_reg, auto_range_next;
    logic       unused_range_in;

    assign unused_range_in = ^range_in;
    assign range_src       = auto_range_reg;

    always_comb begin
        auto_range_next = auto_range_reg;
        if (settle_done) begin
            if (ovf_final && (meas_range_reg != 2'd0))
                auto_range_next = meas_range_reg - 2'd1;
            else if (cnt_msd_zero_in && (meas_range_reg != 2'd3))
                auto_range_next = meas_range_reg + 2'd1;
            else
                auto_range_next = meas_range_reg;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)
            auto_range_reg <= 2'd0;
        else
            auto_range_reg <= auto_range_next;
    end
`else
    logic unused_msd_zero;

    assign unused_msd_zero = cnt_msd_zero_in;
    assign range_src       = range_in;
`endif

    always_comb begin
        case (meas_range_reg)
            2'd0:    gate_load = GATE_LOAD_0;
            2'd1:    gate_load = GATE_LOAD_1;
            2'd2:    gate_load = GATE_LOAD_2;
            default: gate_load = GATE_LOAD_3;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        ovf_acc_next     = ovf_acc_reg;
        overflow_next    = overflow_reg;
        meas_range_next  = meas_range_reg;
        refresh_stb_next = 1'b0;
        load_range       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_in) begin
                    state_next = CLEAR;
                    cnt_next   = CLEAR_LOAD;
                    load_range = 1'b1;
                end
            end
            CLEAR: begin
                ovf_acc_next = 1'b0;
                if (cnt_reg == 32'd0) begin
                    state_next = GATE;
                    cnt_next   = gate_load;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            GATE: begin
                ovf_acc_next = ovf_final;
                if (cnt_reg == 32'd0) begin
                    state_next = SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            SETTLE: begin
                ovf_acc_next = ovf_final;
                if (settle_done) begin
                    state_next    = REFRESH;
                    overflow_next = ovf_final;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            REFRESH: begin
                if (streamer_ready_in) begin
                    state_next       = WAIT_ACK;
                    refresh_stb_next = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (!streamer_ready_in)
                    state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (streamer_ready_in) begin
                    if (start_in) begin
                        state_next = CLEAR;
                        cnt_next   = CLEAR_LOAD;
                        load_range = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (load_range)
            meas_range_next = range_src;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Output flops are loaded from the next state so they line up with state_reg.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            cnt_reg         <= 32'd0;
            ovf_acc_reg     <= 1'b0;
            overflow_reg    <= 1'b0;
            meas_range_reg  <= 2'd0;
            cnt_enable_reg  <= 1'b0;
            cnt_reset_reg   <= 1'b0;
            refresh_stb_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            ovf_acc_reg     <= ovf_acc_next;
            overflow_reg    <= overflow_next;
            meas_range_reg  <= meas_range_next;
            cnt_enable_reg  <= (state_next == GATE);
            cnt_reset_reg   <= (state_next == CLEAR);
            refresh_stb_reg <= refresh_stb_next;
            busy_reg        <= (state_next != IDLE);
        end
    end

    assign cnt_enable_out  = cnt_enable_reg;
    assign cnt_reset_out   = cnt_reset_reg;
    assign refresh_stb_out = refresh_stb_reg;
    assign range_out       = meas_range_reg;
    assign dec_point_out   = {1'b0, meas_range_reg};
    assign overflow_out    = overflow_reg;
    assign busy_out        = busy_reg;
endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer with GATE_BASE=10, CLEAR_CYCLES=2, SETTLE_CYCLES=4 and a small streamer model.
// Define GATE_SEQUENCER_AUTORANGE_EN for the autorange sequence instead of the manual-range one.
module tb_gate_sequencer;
    logic       clk_in = 1'b0;
    logic       reset_in, start_in, cnt_overflow_in, cnt_msd_zero_in, streamer_ready_in;
    logic [1:0] range_in;
    logic       cnt_enable_out, cnt_reset_out, refresh_stb_out, overflow_out, busy_out;
    logic [1:0] range_out;
    logic [2:0] dec_point_out;

    always #5 clk_in = ~clk_in;

    gate_sequencer #(.GATE_BASE(10), .CLEAR_CYCLES(2), .SETTLE_CYCLES(4)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .range_in(range_in),
        .cnt_overflow_in(cnt_overflow_in), .cnt_msd_zero_in(cnt_msd_zero_in),
        .streamer_ready_in(streamer_ready_in), .cnt_enable_out(cnt_enable_out),
        .cnt_reset_out(cnt_reset_out), .refresh_stb_out(refresh_stb_out),
        .range_out(range_out), .dec_point_out(dec_point_out),
        .overflow_out(overflow_out), .busy_out(busy_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("ok   %s: %0d", tag, act);
        end
    endtask

    // Monitor + streamer model, all sampled on the falling edge.
    int en_run = 0, rst_run = 0, last_en = 0, last_rst = 0;
    int stb_count = 0, stb_width = 0, stb_maxw = 0, overlap_cnt = 0, first_act = 0;
    int busy_cnt = 0;
    bit hold_ready = 1'b0;

    initial begin
        streamer_ready_in = 1'b1;
        forever begin
            @(negedge clk_in);
            if (reset_in) begin
                en_run = 0; rst_run = 0; first_act = 0; stb_width = 0;
            end else begin
                if (cnt_enable_out && cnt_reset_out) overlap_cnt++;
                if (cnt_reset_out) begin
                    rst_run++;
                    if (first_act == 0) first_act = 1;
                end
                if (cnt_enable_out) begin
                    en_run++;
                    if (first_act == 0) first_act = 2;
                end
                if (refresh_stb_out) begin
                    stb_width++;
                    if (stb_width > stb_maxw) stb_maxw = stb_width;
                    if (stb_width == 1) begin
                        stb_count++;
                        last_en = en_run; last_rst = rst_run;
                        en_run = 0; rst_run = 0;
                    end
                end else begin
                    stb_width = 0;
                end
            end
            if (hold_ready) streamer_ready_in = 1'b0;
            else if (refresh_stb_out) begin busy_cnt = 3; streamer_ready_in = 1'b0; end
            else if (busy_cnt > 0) begin busy_cnt--; streamer_ready_in = 1'b0; end
            else streamer_ready_in = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int start_cnt;
        int n;
        start_cnt = stb_count;
        n = 0;
        while (stb_count == start_cnt && n < budget) begin tick(); n++; end
        if (stb_count == start_cnt) check_value({tag, "_strobe_timeout"}, 0, 1);
    endtask

    task automatic wait_enable(input string tag, input logic level, input int budget);
        int n;
        n = 0;
        while (cnt_enable_out != level && n < budget) begin tick(); n++; end
        if (cnt_enable_out != level) check_value({tag, "_enable_timeout"}, 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_enable"}, cnt_enable_out, 0);
        check_value({tag, "_reset"}, cnt_reset_out, 0);
        check_value({tag, "_stb"}, refresh_stb_out, 0);
        check_value({tag, "_ovf"}, overflow_out, 0);
        check_value({tag, "_busy"}, busy_out, 0);
        check_value({tag, "_range"}, range_out, 0);
        check_value({tag, "_dp"}, dec_point_out, 0);
    endtask

`ifdef GATE_SEQUENCER_AUTORANGE_EN
    int exp_range[10] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0};
    int exp_len[4]    = '{10, 100, 1000, 10000};
`endif

    initial begin
        int snap;
        reset_in = 1'b1; start_in = 1'b0; range_in = 2'd1;
        cnt_overflow_in = 1'b0; cnt_msd_zero_in = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset_in = 1'b0;
        repeat (3) tick();
        check_value("idle_busy", busy_out, 0);

`ifdef GATE_SEQUENCER_AUTORANGE_EN
        cnt_msd_zero_in = 1'b1;
        start_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_strobe($sformatf("auto%0d", i), 12000);
            check_value($sformatf("auto%0d_range", i), range_out, exp_range[i]);
            check_value($sformatf("auto%0d_gate", i), last_en, exp_len[exp_range[i]]);
            check_value($sformatf("auto%0d_ovf", i), overflow_out, (i >= 5) ? 1 : 0);
            if (i == 4) begin
                cnt_msd_zero_in = 1'b0;
                cnt_overflow_in = 1'b1;
            end
        end
        start_in = 1'b0;
        cnt_overflow_in = 1'b0;
        repeat (20) tick();
        check_value("auto_end_busy", busy_out, 0);
`else
        // Basic measurement at range 1
        start_in = 1'b1;
        wait_strobe("m1", 500);
        check_value("m1_clear_len", last_rst, 2);
        check_value("m1_gate_len", last_en, 100);
        check_value("m1_range", range_out, 1);
        check_value("m1_dp", dec_point_out, 1);
        check_value("m1_ovf", overflow_out, 0);
        check_value("m1_busy", busy_out, 1);

        // Single-cycle overflow mid-gate, then a clean gate
        wait_enable("m2", 1'b1, 100);
        repeat (20) tick();
        cnt_overflow_in = 1'b1;
        tick();
        cnt_overflow_in = 1'b0;
        wait_strobe("m2", 500);
        check_value("m2_ovf", overflow_out, 1);
        check_value("m2_gate_len", last_en, 100);
        wait_strobe("m3", 500);
        check_value("m3_ovf_cleared", overflow_out, 0);
        check_value("m3_range", range_out, 1);

        // range_in is only latched when a new measurement starts
        range_in = 2'd0;
        wait_enable("m4", 1'b1, 100);
        range_in = 2'd2;
        wait_strobe("m4", 500);
        check_value("m4_gate_len", last_en, 10);
        check_value("m4_range", range_out, 0);
        check_value("m4_dp", dec_point_out, 0);

        // Streamer not ready: no strobe until it is
        wait_enable("m5", 1'b1, 100);
        hold_ready = 1'b1;
        wait_enable("m5_end", 1'b0, 2000);
        snap = stb_count;
        repeat (60) tick();
        check_value("m5_no_stb_while_busy", stb_count - snap, 0);
        check_value("m5_busy_held", busy_out, 1);
        hold_ready = 1'b0;
        wait_strobe("m5", 100);
        repeat (3) tick();
        check_value("m5_one_stb", stb_count - snap, 1);
        check_value("m5_gate_len", last_en, 1000);
        check_value("m5_dp", dec_point_out, 2);

        // Dropping start mid-gate finishes the measurement, then idles
        range_in = 2'd0;
        wait_enable("m6", 1'b1, 100);
        repeat (3) tick();
        start_in = 1'b0;
        wait_strobe("m6", 500);
        check_value("m6_gate_len", last_en, 10);
        snap = stb_count;
        repeat (20) tick();
        check_value("m6_idle_busy", busy_out, 0);
        repeat (30) tick();
        check_value("m6_no_more_stb", stb_count - snap, 0);
        check_value("m6_no_reset", cnt_reset_out, 0);

        // Asynchronous reset at gate cycle 37, then restart
        range_in = 2'd1;
        start_in = 1'b1;
        wait_enable("m7", 1'b1, 100);
        repeat (36) tick();
        check_value("m7_in_gate", cnt_enable_out, 1);
        reset_in = 1'b1;
        #1;
        check_value("m7_async_enable", cnt_enable_out, 0);
        check_value("m7_async_busy", busy_out, 0);
        check_value("m7_async_range", range_out, 0);
        check_value("m7_async_dp", dec_point_out, 0);
        repeat (2) tick();
        check_all_zero("m7_reset");
        reset_in = 1'b0;
        wait_strobe("m8", 500);
        check_value("m8_first_is_clear", first_act, 1);
        check_value("m8_clear_len", last_rst, 2);
        check_value("m8_gate_len", last_en, 100);
        start_in = 1'b0;
        repeat (20) tick();
`endif

        check_value("no_enable_reset_overlap", overlap_cnt, 0);
        check_value("strobe_width", stb_maxw, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
